// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one reg_bank -> ALUX -> reg_bank operation per accepted instruction.
// Define ALU_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with a one-cycle op_err pulse.
module alu_seq_ctrl
`ifdef ALU_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W = 7
)
`endif
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [19:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic [3:0]  seloutA_o,
    output logic [3:0]  seloutB_o,
    output logic        enrregA_o,
    output logic        enrregB_o,
    output logic        cnstA_o,
    output logic        cnstB_o,
    output logic        regwen_o,
    output logic [3:0]  selwreg_o,
    output logic [1:0]  endwreg_o,
    output logic [3:0]  opr_o,
    output logic        start_o,
    input  logic        alu_done_i,
    output logic        op_done_o,
    output logic        op_err_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WB} state_e;
    state_e state_q, state_d;
    logic [19:0] instr_q, instr_d;
    logic to_hit;
    logic rd_ph;
`ifdef ALU_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q;
    logic err_q;
    assign to_hit = cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
            err_q <= state_q == WAIT && !alu_done_i && to_hit;
        end
    end
    assign op_err_o = err_q;
`else
    assign to_hit = 1'b0;
    assign op_err_o = 1'b0;
`endif
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: if (instr_valid_i) begin
                instr_d = instr_i;
                state_d = READ;
            end
            READ: state_d = EXEC;
            EXEC: state_d = WAIT;
            WAIT: state_d = alu_done_i ? WB : to_hit ? IDLE : WAIT;
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Read selects stay on through EXEC so the reg_bank output registers hold their operands.
    assign rd_ph         = state_q == READ || state_q == EXEC;
    assign instr_ready_o = state_q == IDLE;
    assign busy_o        = state_q != IDLE;
    assign seloutA_o     = rd_ph ? instr_q[7:4] : '0;
    assign seloutB_o     = rd_ph ? instr_q[3:0] : '0;
    assign enrregA_o     = state_q == READ;
    assign enrregB_o     = state_q == READ;
    assign cnstA_o       = state_q == READ ? instr_q[18] : 1'b0;
    assign cnstB_o       = state_q == READ ? instr_q[19] : 1'b0;
    assign start_o       = state_q == EXEC;
    assign opr_o         = state_q == EXEC || state_q == WAIT ? instr_q[15:12] : '0;
    assign regwen_o      = state_q == WB;
    assign op_done_o     = state_q == WB;
    assign selwreg_o     = state_q == WB ? instr_q[11:8] : '0;
    assign endwreg_o     = state_q == WB ? instr_q[17:16] : '0;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed stimulus against a cycle-count model of the sequencer and a simple ALUX responder.
module tb_alu_seq_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [19:0] instr = '0;
    logic instr_valid = 1'b0;
    logic alu_done = 1'b0;
    logic instr_ready_o, enrregA_o, enrregB_o, cnstA_o, cnstB_o, regwen_o, start_o, op_done_o, op_err_o, busy_o;
    logic [3:0] seloutA_o, seloutB_o, selwreg_o, opr_o;
    logic [1:0] endwreg_o;
`ifdef ALU_TIMEOUT_EN
    localparam int TO = 8;
    localparam bit TO_EN = 1'b1;
    alu_seq_ctrl #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
`else
    localparam int TO = 0;
    localparam bit TO_EN = 1'b0;
    alu_seq_ctrl dut (
`endif
        .clock_i(clock), .reset_i(reset), .instr_i(instr), .instr_valid_i(instr_valid),
        .instr_ready_o(instr_ready_o), .seloutA_o(seloutA_o), .seloutB_o(seloutB_o),
        .enrregA_o(enrregA_o), .enrregB_o(enrregB_o), .cnstA_o(cnstA_o), .cnstB_o(cnstB_o),
        .regwen_o(regwen_o), .selwreg_o(selwreg_o), .endwreg_o(endwreg_o), .opr_o(opr_o),
        .start_o(start_o), .alu_done_i(alu_done), .op_done_o(op_done_o), .op_err_o(op_err_o),
        .busy_o(busy_o)
    );
    always #5 clock = ~clock;
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // ALUX stand-in: raises done for one cycle alu_lat cycles after start (0 = never).
    int alu_lat = 1;
    int cd = 0;
    always @(negedge clock) begin
        alu_done = 1'b0;
        if (start_o) cd = alu_lat;
        else if (cd > 0) begin
            cd--;
            alu_done = cd == 0;
        end
    end
    // Model: m_t counts cycles since acceptance (1 = read, 2 = start, >=3 wait), m_wb is the write-back cycle.
    logic m_busy = 1'b0, m_err = 1'b0;
    int m_t = 0, m_wb = 0;
    logic [19:0] m_ins = '0;
    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0; m_err <= 1'b0; m_t <= 0; m_wb <= 0;
        end else begin
            m_err <= 1'b0;
            if (!m_busy) begin
                if (instr_valid) begin
                    m_busy <= 1'b1; m_t <= 1; m_wb <= 0; m_ins <= instr;
                end
            end else if (m_t == m_wb) begin
                m_busy <= 1'b0; m_t <= 0; m_wb <= 0;
            end else begin
                m_t <= m_t + 1;
                if (m_t >= 3 && alu_done) m_wb <= m_t + 1;
                else if (TO_EN && m_t >= 3 && m_t - 2 == TO) begin
                    m_busy <= 1'b0; m_err <= 1'b1; m_t <= 0;
                end
            end
        end
    end
    bit chk_en = 1'b0;
    logic [3:0] wb_q[$];
    logic rd_e, ex_e, wt_e, wb_e;
    always @(negedge clock) if (chk_en) begin
        rd_e = m_busy && m_t == 1;
        ex_e = m_busy && m_t == 2;
        wt_e = m_busy && m_t >= 3 && m_t != m_wb;
        wb_e = m_busy && m_wb != 0 && m_t == m_wb;
        chk("instr_ready", 32'(instr_ready_o), 32'(!m_busy));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("enrregA", 32'(enrregA_o), 32'(rd_e));
        chk("enrregB", 32'(enrregB_o), 32'(rd_e));
        chk("start", 32'(start_o), 32'(ex_e));
        chk("regwen", 32'(regwen_o), 32'(wb_e));
        chk("op_done", 32'(op_done_o), 32'(wb_e));
        chk("op_err", 32'(op_err_o), 32'(m_err));
        if (rd_e || ex_e) begin
            chk("seloutA", 32'(seloutA_o), 32'(m_ins[7:4]));
            chk("seloutB", 32'(seloutB_o), 32'(m_ins[3:0]));
        end
        if (rd_e) begin
            chk("cnstA", 32'(cnstA_o), 32'(m_ins[18]));
            chk("cnstB", 32'(cnstB_o), 32'(m_ins[19]));
        end
        if (ex_e || wt_e) chk("opr", 32'(opr_o), 32'(m_ins[15:12]));
        if (wb_e) begin
            chk("selwreg", 32'(selwreg_o), 32'(m_ins[11:8]));
            chk("endwreg", 32'(endwreg_o), 32'(m_ins[17:16]));
        end
        if (!m_busy)
            chk("idle_zero", 32'({seloutA_o, seloutB_o, enrregA_o, enrregB_o, cnstA_o, cnstB_o, regwen_o,
                                  selwreg_o, endwreg_o, opr_o, start_o, op_done_o}), 32'd0);
        if (op_done_o) wb_q.push_back(selwreg_o);
    end
    logic [3:0] snap_sa[64], snap_sb[64], snap_opr[64], snap_sw[64];
    logic snap_en[64], snap_st[64], snap_rw[64];
    // Issues one instruction from an IDLE negedge; cyc is the cycle (acceptance cycle = 0) of op_done/op_err.
    task automatic run_op(input logic [19:0] ins, input int lat, output int cyc, output bit err,
                          output int starts, output int wens);
        alu_lat = lat; instr = ins; instr_valid = 1'b1;
        cyc = 0; err = 1'b0; starts = 0; wens = 0;
        for (int k = 1; k <= 60 && cyc == 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                instr_valid = 1'b0;
                instr = 20'hFFFFF;
            end
            snap_sa[k] = seloutA_o; snap_sb[k] = seloutB_o; snap_opr[k] = opr_o; snap_sw[k] = selwreg_o;
            snap_en[k] = enrregA_o; snap_st[k] = start_o; snap_rw[k] = regwen_o;
            starts += int'(start_o);
            wens += int'(regwen_o);
            if (op_done_o || op_err_o) begin
                cyc = k;
                err = op_err_o;
            end
        end
    endtask
    localparam logic [19:0] LST[4] = '{20'h51663, 20'hF2078, 20'h24ABB, 20'h8FF0F};
    localparam logic [3:0] EXP_RD[4] = '{4'h6, 4'h0, 4'hA, 4'hF};
    initial begin
        int cyc, st, we, idx;
        bit er, same;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_regwen", 32'(regwen_o), 32'd0);
        chk("rst_op_err", 32'(op_err_o), 32'd0);
        run_op(20'h03512, 1, cyc, er, st, we);
        chk("t1_cycles", 32'(cyc), 32'd4);
        chk("t1_starts", 32'(st), 32'd1);
        chk("t1_writes", 32'(we), 32'd1);
        chk("t1_seloutA", 32'(snap_sa[1]), 32'd1);
        chk("t1_seloutB", 32'(snap_sb[1]), 32'd2);
        chk("t1_enrreg", 32'(snap_en[1]), 32'd1);
        chk("t1_start_t2", 32'(snap_st[2]), 32'd1);
        chk("t1_opr_t2", 32'(snap_opr[2]), 32'd3);
        chk("t1_regwen_t4", 32'(snap_rw[4]), 32'd1);
        chk("t1_selwreg_t4", 32'(snap_sw[4]), 32'd5);
        @(negedge clock);
        chk("t1_busy_t5", 32'(busy_o), 32'd0);
        run_op(20'hA794C, 10, cyc, er, st, we);
        chk("t2_cycles", 32'(cyc), 32'd13);
        chk("t2_starts", 32'(st), 32'd1);
        chk("t2_writes", 32'(we), 32'd1);
        same = 1'b1;
        for (int k = 2; k <= 12; k++) if (snap_opr[k] !== 4'h7) same = 1'b0;
        chk("t2_opr_hold", 32'(same), 32'd1);
        @(negedge clock);
        wb_q.delete();
        alu_lat = 1;
        idx = 0;
        instr = LST[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 100 && idx < 4; c++) begin
            automatic bit acc = instr_ready_o;
            @(negedge clock);
            if (acc) begin
                idx++;
                if (idx < 4) instr = LST[idx];
            end
        end
        instr_valid = 1'b0;
        for (int c = 0; c < 40 && wb_q.size() < 4; c++) @(negedge clock);
        repeat (2) @(negedge clock);
        chk("b2b_count", 32'(wb_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b_selwreg", 32'(i < wb_q.size() ? wb_q[i] : 4'hX), 32'(EXP_RD[i]));
        alu_lat = 0;
        instr = 20'h35321;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst_mid_busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_mid_outs", 32'({busy_o, regwen_o, op_done_o, selwreg_o, opr_o, start_o}), 32'd0);
        run_op(20'h35321, 2, cyc, er, st, we);
        chk("rst_after_cycles", 32'(cyc), 32'd5);
        chk("rst_after_writes", 32'(we), 32'd1);
        @(negedge clock);
`ifdef ALU_TIMEOUT_EN
        run_op(20'h14789, 0, cyc, er, st, we);
        chk("to_cycles", 32'(cyc), 32'd11);
        chk("to_err", 32'(er), 32'd1);
        chk("to_writes", 32'(we), 32'd0);
        @(negedge clock);
        run_op(20'h14789, 8, cyc, er, st, we);
        chk("to_edge_cycles", 32'(cyc), 32'd11);
        chk("to_edge_err", 32'(er), 32'd0);
        chk("to_edge_writes", 32'(we), 32'd1);
        @(negedge clock);
        run_op(20'h14789, 9, cyc, er, st, we);
        chk("to_late_err", 32'(er), 32'd1);
        chk("to_late_writes", 32'(we), 32'd0);
        repeat (2) @(negedge clock);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequencer that executes one register-to-register ALU operation per accepted instruction.
- Per instruction: reads two operands from reg_bank, starts ALUX, waits for its done, writes the result back to reg_bank.
- Sits between the instruction source and the reg_bank/ALUX pair. Drives every reg_bank control port and ALUX opr/start.
- The data path itself (outA/outB -> ALUX -> inA) is wired at top level, not through this block.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT for alu_done before abort (only with ALU_TIMEOUT_EN).
- TO_W, 7, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- instr  in  20  {cnstB, cnstA, endw[1:0], opr[3:0], rd[3:0], ra[3:0], rb[3:0]}
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept; high only in IDLE
- seloutA  out  4  reg_bank read select A (=ra)
- seloutB  out  4  reg_bank read select B (=rb)
- enrregA  out  1  reg_bank output register A enable
- enrregB  out  1  reg_bank output register B enable
- cnstA  out  1  reg_bank constant select A (from instr)
- cnstB  out  1  reg_bank constant select B (from instr)
- regwen  out  1  reg_bank write enable
- selwreg  out  4  reg_bank write select (=rd)
- endwreg  out  2  reg_bank write mode (=endw, passed unchanged)
- opr  out  4  ALUX operation code
- start  out  1  ALUX start pulse
- alu_done  in  1  ALUX done
- op_done  out  1  one-cycle pulse: result written
- op_err  out  1  one-cycle pulse: ALU timeout abort
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - All outputs are 0 except instr_ready, which is 1.
  - Latched instruction fields and timeout counter are cleared.
- Reset asserted mid-operation aborts with no write and no op_done.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, latch instr into internal fields and go to READ.
  - instr is ignored in all other states.
- READ (1 cycle): seloutA=ra, seloutB=rb, cnstA/cnstB from the instruction, enrregA=enrregB=1. Next state is EXEC.
- EXEC (1 cycle):
  - start=1, opr=latched opr; opr is held stable through WAIT.
  - enrregA/B=0; seloutA/B are held.
  - Next state is WAIT.
- WAIT:
  - alu_done is sampled here only; a done seen during EXEC is ignored.
  - On alu_done=1, go to WB.
  - The timeout counter increments each WAIT cycle.
- WB (1 cycle): regwen=1, selwreg=rd, endwreg=endw, op_done=1. Next state is IDLE.
- Minimum latency: accept at T0, READ T1, EXEC T2, WAIT T3 (alu_done high), WB T4. instr_ready is high again at T5.
- Back-to-back instructions therefore take at least 5 cycles each.
- rd may equal ra or rb; the write occurs after the reads, so there is no hazard inside the block.
- rd=0 is a normal register; it is not hardwired to zero.
- All outputs are registered from state and latched fields; no input-to-output combinational paths except through state.

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - In WAIT, if the counter reaches TIMEOUT_CYCLES without alu_done, go to IDLE with op_err=1 for one cycle.
  - No regwen and no op_done on abort.
  - Counter clears on entry to WAIT.
  - alu_done in the same cycle as the limit takes priority: go to WB, no error.
- Undefined: WAIT waits indefinitely; op_err is tied to 0; no counter logic is present.

Test Plan:
- Single op: instr {0,0,00,0011,0101,0001,0010}, ALUX model done 1 cycle after start:
  - seloutA=1, seloutB=2, enrregA/B=1 at T1; start=1, opr=3 at T2.
  - regwen=1, selwreg=5, op_done=1 at T4; busy low at T5.
- Variable ALU latency: done 10 cycles after start -> start is exactly one pulse; regwen/op_done exactly one cycle after done; opr constant throughout WAIT.
- Back-to-back: instr_valid held high with 4 distinct instructions -> each accepted only when instr_ready=1; 4 op_done pulses; selwreg sequence matches each rd.
- Reset mid-op: assert reset in WAIT -> next cycle all outputs 0 except instr_ready=1, no regwen; a new instruction then completes normally.
- Timeout (ALU_TIMEOUT_EN, TIMEOUT_CYCLES=8): alu_done never asserted -> op_err pulses after 8 WAIT cycles, no regwen, back to IDLE.
- Timeout boundary: done on the limit cycle -> WB taken, op_err stays 0.
